crossbar_arbiter: RTL and testbench

- N-to-1 round-robin arbiter that sits directly downstream of the crossbar_fifo instances, one FIFO per source port.
- Merges the per-source AXI-Stream FIFO outputs into one crossbar output port.
- Locks the grant to one source for a whole packet (tlast-delimited) and tags each beat with its source index.
- Registered output: one-cycle latency and full throughput of 1 beat/cycle.

---
 rtl/crossbar_pkg.sv | 42 ++++
 rtl/crossbar_rr_picker.sv | 31 +++
 rtl/crossbar_arbiter.sv | 119 +++++++++++
 tb/tb_crossbar_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Purpose : shared types, widths and round-robin helper for the crossbar output arbiter.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package crossbar_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_INPUTS = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Upper bound on sources supported by the round-robin helper.
    localparam int MAX_INPUTS = 32;

    // Returns a one-hot grant: the first requester found scanning last+1, last+2, ...
    // modulo n. The wrap uses an explicit compare so non-power-of-two n works.
    function automatic logic [MAX_INPUTS-1:0] next_rr_index(
        input logic [MAX_INPUTS-1:0] req,
        input logic [4:0]            last,
        input logic [5:0]            n
    );
        logic [MAX_INPUTS-1:0] gnt;
        logic [5:0]            idx;
        logic                  found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_INPUTS; k++) begin
            idx = {1'b0, last} + 6'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((6'(k) <= n) && !found && req[idx[4:0]]) begin
                gnt[idx[4:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/crossbar_rr_picker.sv
// Purpose : rotate-priority encoder choosing the next requester after last_grant.
// Latency : purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports   : req (per-source request), last_grant (previous winner),
//           grant_valid (any requester), grant_idx (winner index).
module crossbar_rr_picker
    import crossbar_pkg::*;
#(
    parameter  int NUM_INPUTS = DEFAULT_NUM_INPUTS,
    localparam int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [ID_WIDTH-1:0]   last_grant,
    output logic                  grant_valid,
    output logic [ID_WIDTH-1:0]   grant_idx
);

    logic [MAX_INPUTS-1:0] onehot;

    always_comb begin
        onehot      = next_rr_index(MAX_INPUTS'(req), 5'(last_grant), 6'(NUM_INPUTS));
        grant_valid = |onehot;
        grant_idx   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (onehot[i]) begin
                grant_idx = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/crossbar_arbiter.sv
// Purpose : N-to-1 packet-locked round-robin merge of per-source AXI-Stream FIFOs, beats tagged with source id.
// Latency : one cycle input-to-output through a single output register, 1 beat/cycle sustained.
// Backpressure: only the granted source sees tready, and only while the output register is free.
// Ports   : clk/resetn; s_axis_data_* (NUM_INPUTS sources, packed data); m_axis_data_* merged output + tid.
module crossbar_arbiter
    import crossbar_pkg::*;
#(
    parameter  int NUM_INPUTS = DEFAULT_NUM_INPUTS,
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    localparam int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [NUM_INPUTS-1:0]            s_axis_data_tvalid,
    output logic [NUM_INPUTS-1:0]            s_axis_data_tready,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_data_tdata,
    input  logic [NUM_INPUTS-1:0]            s_axis_data_tlast,
    output logic                             m_axis_data_tvalid,
    input  logic                             m_axis_data_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_data_tdata,
    output logic                             m_axis_data_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_data_tid
);

    arb_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0]   lock_idx_q, lock_idx_d;
    logic                  out_vld_q, out_vld_d;
    logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
    logic                  out_last_q, out_last_d;
    logic [ID_WIDTH-1:0]   out_tid_q, out_tid_d;

    logic                  pick_vld;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic                  sel_en;
    logic [ID_WIDTH-1:0]   sel_idx;
    logic                  sel_vld;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  sel_last;
    logic                  out_free;
    logic                  accept;

    crossbar_rr_picker #(
        .NUM_INPUTS (NUM_INPUTS)
    ) u_picker (
        .req         (s_axis_data_tvalid),
        .last_grant  (last_grant_q),
        .grant_valid (pick_vld),
        .grant_idx   (pick_idx)
    );

    always_comb begin
        // While locked the grant ignores other requesters, even if the owner drops tvalid.
        sel_en   = (state_q == LOCKED) || pick_vld;
        sel_idx  = (state_q == LOCKED) ? lock_idx_q : pick_idx;
        out_free = !out_vld_q || m_axis_data_tready;

        s_axis_data_tready = '0;
        sel_vld  = 1'b0;
        sel_dat  = '0;
        sel_last = 1'b0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (sel_idx == ID_WIDTH'(i)) begin
                // resetn gate keeps every tready low while reset is asserted.
                s_axis_data_tready[i] = resetn && out_free && sel_en;
                sel_vld  = s_axis_data_tvalid[i];
                sel_dat  = s_axis_data_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_last = s_axis_data_tlast[i];
            end
        end
        accept = out_free && sel_en && sel_vld;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_idx_d   = lock_idx_q;
        out_vld_d    = out_vld_q;
        out_dat_d    = out_dat_q;
        out_last_d   = out_last_q;
        out_tid_d    = out_tid_q;

        if (accept) begin
            out_vld_d    = 1'b1;
            out_dat_d    = sel_dat;
            out_last_d   = sel_last;
            out_tid_d    = sel_idx;
            last_grant_d = sel_idx;
            lock_idx_d   = sel_idx;
            state_d      = sel_last ? IDLE : LOCKED;
        end else if (m_axis_data_tready) begin
            out_vld_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            last_grant_q <= ID_WIDTH'(NUM_INPUTS - 1);
            lock_idx_q   <= '0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            out_last_q   <= 1'b0;
            out_tid_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_idx_q   <= lock_idx_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            out_last_q   <= out_last_d;
            out_tid_q    <= out_tid_d;
        end
    end

    assign m_axis_data_tvalid = out_vld_q;
    assign m_axis_data_tdata  = out_dat_q;
    assign m_axis_data_tlast  = out_last_q;
    assign m_axis_data_tid    = out_tid_q;

endmodule

// File: tb/tb_crossbar_arbiter.sv
// Purpose : randomized self-checking bench for crossbar_arbiter against a packet-level round-robin model.
// Latency : model expects output one cycle after each accepted beat.
// Backpressure: bench toggles m_axis_data_tready and source tvalid gating at random.
module tb_crossbar_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N-1:0]    s_vld;
    logic [N-1:0]    s_rdy;
    logic [N*DW-1:0] s_dat;
    logic [N-1:0]    s_last;
    logic            m_vld;
    logic            m_rdy;
    logic [DW-1:0]   m_dat;
    logic            m_last;
    logic [IW-1:0]   m_tid;

    always #5 clk = ~clk;

    crossbar_arbiter #(
        .NUM_INPUTS (N),
        .DATA_WIDTH (DW)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .s_axis_data_tvalid (s_vld),
        .s_axis_data_tready (s_rdy),
        .s_axis_data_tdata  (s_dat),
        .s_axis_data_tlast  (s_last),
        .m_axis_data_tvalid (m_vld),
        .m_axis_data_tready (m_rdy),
        .m_axis_data_tdata  (m_dat),
        .m_axis_data_tlast  (m_last),
        .m_axis_data_tid    (m_tid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending beats per source ({last,data}), priority pointer,
    // packet owner (-1 = none) and the expected contents of the output register.
    logic [DW:0]   src_q [N][$];
    int            m_ptr;
    int            m_lock;
    logic          e_vld;
    logic [DW-1:0] e_dat;
    logic          e_last;
    logic [IW-1:0] e_tid;
    logic [N-1:0]  e_rdy;

    function automatic int pick();
        if (m_lock >= 0) return m_lock;
        for (int k = 1; k <= N; k++) begin
            if (s_vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        m_ptr  = N - 1;
        m_lock = -1;
        e_vld  = 1'b0;
        e_dat  = '0;
        e_last = 1'b0;
        e_tid  = '0;
    endtask

    task automatic push_pkt(input int src, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++) begin
            logic [DW:0] beat;
            beat = {(b == len - 1), base + DW'(b)};
            src_q[src].push_back(beat);
        end
    endtask

    // Present inputs at the falling edge and compute the expected per-source ready.
    task automatic drive(input logic [N-1:0] gate, input logic rdy);
        int g;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && gate[i]) begin
                s_vld[i]            = 1'b1;
                s_dat[i*DW +: DW]   = src_q[i][0][DW-1:0];
                s_last[i]           = src_q[i][0][DW];
            end else begin
                s_vld[i]            = 1'b0;
                s_dat[i*DW +: DW]   = $urandom;
                s_last[i]           = 1'($urandom_range(0, 1));
            end
        end
        m_rdy = rdy;
        g     = pick();
        e_rdy = '0;
        if (g >= 0 && (!e_vld || rdy)) e_rdy[g] = 1'b1;
        #1;
    endtask

    // Clock edge: apply the round-robin / packet-lock rules to the model.
    task automatic advance();
        int   g;
        logic free;
        @(posedge clk);
        g    = pick();
        free = !e_vld || m_rdy;
        if (free && g >= 0 && s_vld[g]) begin
            e_vld  = 1'b1;
            e_dat  = src_q[g][0][DW-1:0];
            e_last = src_q[g][0][DW];
            e_tid  = IW'(g);
            m_ptr  = g;
            m_lock = e_last ? -1 : g;
            void'(src_q[g].pop_front());
        end else if (m_rdy) begin
            e_vld = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        s_vld  = '0;
        s_dat  = '0;
        s_last = '0;
        m_rdy  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({m_vld, m_last, m_tid, m_dat} !== '0) begin
            n_bad++;
            $display("FAIL reset_out: got vld=%b last=%b tid=%0d dat=%h want all zero", m_vld, m_last, m_tid, m_dat);
        end
        s_vld = 4'b1111;
        #1;
        n_cmp++;
        if (s_rdy !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_rdy: got %b want 0000", s_rdy);
        end
        s_vld = '0;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive('0, 1'b1);
            n_cmp++;
            if (s_rdy !== 4'b0000) begin
                n_bad++;
                $display("FAIL idle_rdy: got %b want 0000", s_rdy);
            end
            advance();
            n_cmp++;
            if (m_vld !== 1'b0 || m_tid !== '0) begin
                n_bad++;
                $display("FAIL idle_out: got vld=%b tid=%0d want vld=0 tid=0", m_vld, m_tid);
            end
        end
    endtask

    task automatic test_two_single();
        logic [DW-1:0] want_dat [2];
        logic [IW-1:0] want_tid [2];
        want_dat[0] = 32'hA0; want_tid[0] = 2'd0;
        want_dat[1] = 32'hA2; want_tid[1] = 2'd2;
        push_pkt(0, 1, 32'hA0);
        push_pkt(2, 1, 32'hA2);
        for (int c = 0; c < 2; c++) begin
            drive(4'b1111, 1'b1);
            advance();
            n_cmp++;
            if (m_vld !== 1'b1 || m_dat !== want_dat[c] || m_tid !== want_tid[c] || m_last !== 1'b1) begin
                n_bad++;
                $display("FAIL two_single[%0d]: got vld=%b dat=%h tid=%0d last=%b want 1 %h %0d 1",
                         c, m_vld, m_dat, m_tid, m_last, want_dat[c], want_tid[c]);
            end
        end
        drive('0, 1'b1);
        advance();
        n_cmp++;
        if (m_vld !== 1'b0) begin
            n_bad++;
            $display("FAIL two_single_drain: got vld=%b want 0", m_vld);
        end
    endtask

    // Generic model-checked run used by the scenario tasks below.
    task automatic run_checked(input string name, input int cycles, input logic [N-1:0] gate,
                               input logic [31:0] rdy_pat, input bit rand_mode);
        logic [N-1:0] g;
        logic         r;
        for (int c = 0; c < cycles; c++) begin
            g = rand_mode ? N'($urandom) : gate;
            r = rand_mode ? ($urandom_range(0, 3) != 0) : rdy_pat[c % 32];
            if (rand_mode && $urandom_range(0, 3) == 0) begin
                push_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), $urandom);
            end
            drive(g, r);
            n_cmp++;
            if (s_rdy !== e_rdy) begin
                n_bad++;
                $display("FAIL %s_rdy cyc %0d: got %b want %b", name, c, s_rdy, e_rdy);
            end
            advance();
            n_cmp++;
            if (m_vld !== e_vld || m_dat !== e_dat || m_last !== e_last || m_tid !== e_tid) begin
                n_bad++;
                $display("FAIL %s_out cyc %0d: got vld=%b dat=%h last=%b tid=%0d want %b %h %b %0d",
                         name, c, m_vld, m_dat, m_last, m_tid, e_vld, e_dat, e_last, e_tid);
            end
        end
    endtask

    task automatic test_all_rr();
        for (int s = 0; s < N; s++) begin
            for (int p = 0; p < 6; p++) push_pkt(s, 1, DW'(32'h100 * (s + 1) + p));
        end
        run_checked("all_rr", 28, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_locked();
        push_pkt(1, 3, 32'h10);
        push_pkt(0, 1, 32'h50);
        push_pkt(0, 1, 32'h51);
        run_checked("locked", 8, 4'b0011, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_stall();
        push_pkt(2, 4, 32'h20);
        push_pkt(1, 1, 32'h60);
        // m_tready 1,0,0,1 then free-running
        run_checked("stall", 10, 4'b0110, 32'hFFFF_FFF9, 1'b0);
        push_pkt(3, 3, 32'h30);
        // owner drops tvalid mid-packet while another source waits
        run_checked("drop_a", 2, 4'b1000, 32'hFFFF_FFFF, 1'b0);
        push_pkt(0, 1, 32'h70);
        run_checked("drop_b", 3, 4'b0001, 32'hFFFF_FFFF, 1'b0);
        run_checked("drop_c", 4, 4'b1001, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_random();
        run_checked("random", 1500, '0, '0, 1'b1);
        run_checked("drain", 120, 4'b1111, 32'hFFFF_FFFF, 1'b0);
    endtask

    task automatic test_reset_mid();
        push_pkt(3, 5, 32'h3000);
        run_checked("pre_rst", 2, 4'b1000, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({m_vld, m_last, m_tid, m_dat} !== '0) begin
            n_bad++;
            $display("FAIL async_rst_out: got vld=%b last=%b tid=%0d dat=%h want all zero", m_vld, m_last, m_tid, m_dat);
        end
        n_cmp++;
        if (s_rdy !== 4'b0000) begin
            n_bad++;
            $display("FAIL async_rst_rdy: got %b want 0000", s_rdy);
        end
        model_reset();
        s_vld = '0;
        @(negedge clk);
        resetn = 1'b1;
        push_pkt(3, 1, 32'hD3);
        push_pkt(0, 1, 32'hD0);
        drive(4'b1001, 1'b1);
        n_cmp++;
        if (s_rdy !== 4'b0001) begin
            n_bad++;
            $display("FAIL post_rst_rdy: got %b want 0001", s_rdy);
        end
        advance();
        n_cmp++;
        if (m_vld !== 1'b1 || m_tid !== 2'd0 || m_dat !== 32'hD0) begin
            n_bad++;
            $display("FAIL post_rst_first: got vld=%b tid=%0d dat=%h want 1 0 d0", m_vld, m_tid, m_dat);
        end
        run_checked("post_rst", 3, 4'b1001, 32'hFFFF_FFFF, 1'b0);
    endtask

    initial begin
        test_reset();
        test_two_single();
        test_all_rr();
        test_locked();
        test_stall();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
